// File: rtl/sdram_read_frame.sv
// Avalon-MM burst read master: fetches one frame from a DDR frame buffer and
// streams it out as words through a show-ahead FIFO with a valid/ready handshake.
module sdram_read_frame #(
  parameter int unsigned ADDR_W      = 29,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned BURST_LEN   = 32,
  parameter int unsigned FRAME_WORDS = 518400,
  parameter int unsigned FIFO_DEPTH  = 128
) (
  input  logic              clk_200,
  input  logic              reset,
  input  logic              start_read,
  input  logic              buf_sel,
  input  logic [31:0]       reg_addr_buf_1,
  input  logic [31:0]       reg_addr_buf_2,
  output logic [ADDR_W-1:0] avl_address,
  output logic [7:0]        avl_burstcount,
  output logic              avl_read,
  input  logic              avl_waitrequest,
  input  logic [DATA_W-1:0] avl_readdata,
  input  logic              avl_readdatavalid,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_sof,
  output logic              dout_eof,
  output logic              busy,
  output logic              frame_done,
  output logic              err_unexp
);

  localparam int unsigned NBURSTS = FRAME_WORDS / BURST_LEN;
  localparam int unsigned OUT_W   = $clog2(FRAME_WORDS + 1);
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned BUR_W   = $clog2(NBURSTS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   avl_address_q, avl_address_d;
  logic                avl_read_q, avl_read_d;
  logic [CNT_W-1:0]    inflight_q, inflight_d;
  logic [CNT_W-1:0]    fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OUT_W-1:0]    out_cnt_q, out_cnt_d;
  logic [BUR_W-1:0]    bursts_q, bursts_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];

  logic                accept;
  logic                rdv_ok;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_wr;
  logic                pop;
  logic                credit_ok;
  logic [ADDR_W-1:0]   base_addr;

  assign accept     = avl_read_q & ~avl_waitrequest;
  assign rdv_ok     = avl_readdatavalid & (inflight_q != '0);
  assign fifo_full  = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_wr    = rdv_ok & ~fifo_full;
  assign pop        = ~fifo_empty & dout_ready;
  assign base_addr  = buf_sel ? reg_addr_buf_2[ADDR_W-1:0] : reg_addr_buf_1[ADDR_W-1:0];

  // Words already buffered plus words still owed by the slave must leave room for a whole burst.
  assign credit_ok = ({1'b0, fifo_cnt_q} + {1'b0, inflight_q})
                     <= (CNT_W + 1)'(FIFO_DEPTH - BURST_LEN);

  generate
    if (ADDR_W < 32) begin : g_addr_unused
      logic unused_addr_bits;
      assign unused_addr_bits = ^{reg_addr_buf_1[31:ADDR_W], reg_addr_buf_2[31:ADDR_W]};
    end
  endgenerate

  always_comb begin
    state_d       = state_q;
    avl_address_d = avl_address_q;
    avl_read_d    = avl_read_q;
    busy_d        = busy_q;
    frame_done_d  = 1'b0;
    bursts_d      = bursts_q;
    wr_ptr_d      = wr_ptr_q + PTR_W'(fifo_wr);
    rd_ptr_d      = rd_ptr_q + PTR_W'(pop);
    fifo_cnt_d    = fifo_cnt_q + CNT_W'(fifo_wr) - CNT_W'(pop);
    inflight_d    = inflight_q + (accept ? CNT_W'(BURST_LEN) : '0) - CNT_W'(rdv_ok);
    out_cnt_d     = out_cnt_q + OUT_W'(pop);
    err_d         = err_q | (avl_readdatavalid & (inflight_q == '0));

    case (state_q)
      ST_IDLE: begin
        if (start_read) begin
          avl_address_d = base_addr;
          out_cnt_d     = '0;
          bursts_d      = '0;
          inflight_d    = '0;
          avl_read_d    = 1'b1;
          busy_d        = 1'b1;
          state_d       = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (accept) begin
          avl_read_d    = 1'b0;
          avl_address_d = avl_address_q + ADDR_W'(BURST_LEN);
          bursts_d      = bursts_q + 1'b1;
          if (bursts_q == BUR_W'(NBURSTS - 1)) begin
            state_d = ST_DRAIN;
          end
        end else if (!avl_read_q) begin
          // Registered re-check: the sum only shrinks until the next accept, so it stays safe.
          avl_read_d = credit_ok;
        end
      end
      ST_DRAIN: begin
        if (out_cnt_d == OUT_W'(FRAME_WORDS)) begin
          frame_done_d = 1'b1;
          state_d      = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_200) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      avl_address_q <= '0;
      avl_read_q    <= 1'b0;
      inflight_q    <= '0;
      fifo_cnt_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      out_cnt_q     <= '0;
      bursts_q      <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      avl_address_q <= avl_address_d;
      avl_read_q    <= avl_read_d;
      inflight_q    <= inflight_d;
      fifo_cnt_q    <= fifo_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      out_cnt_q     <= out_cnt_d;
      bursts_q      <= bursts_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      err_q         <= err_d;
    end
  end

  always_ff @(posedge clk_200) begin
    if (fifo_wr) begin
      fifo_mem[wr_ptr_q] <= avl_readdata;
    end
  end

  assign avl_address    = avl_address_q;
  assign avl_burstcount = 8'(BURST_LEN);
  assign avl_read       = avl_read_q;
  assign dout_valid     = ~fifo_empty;
  assign dout           = fifo_empty ? '0 : fifo_mem[rd_ptr_q];
  assign dout_sof       = ~fifo_empty & (out_cnt_q == '0);
  assign dout_eof       = ~fifo_empty & (out_cnt_q == OUT_W'(FRAME_WORDS - 1));
  assign busy           = busy_q;
  assign frame_done     = frame_done_q;
  assign err_unexp      = err_q;

endmodule
